req_priority_encoder: RTL
=========================

// Module: req_priority_encoder
// PURPOSE
//  Inverse of the one-hot channel decoder: turns an 8-bit one-hot/multi-hot request vector into a
//  registered 3-bit channel index.
//  Arbitrates when several requests are active and holds the grant until the consumer acks.
//  Sits between DMA channel request lines and the DMAC channel-select logic.
// PARAMETERS
//  IDX_W    3   index width; N_REQ = 2**IDX_W request lines (only 3 is verified)
//  TIMEOUT  16  max cycles in GRANT without ack before forced release; 0 = never time out
// PORTS
//  clk          in   1      rising-edge clock
//  reset_n      in   1      asynchronous, active-low reset
//  req          in   N_REQ  request lines, level-sensitive, bit i = channel i
//  ack          in   1      consumer accepts current grant (valid only while valid=1)
//  valid        out  1      idx/grant_oh hold a live grant
//  idx          out  IDX_W  granted channel number (binary)
//  grant_oh     out  N_REQ  one-hot copy of idx; all-zero when valid=0
//  timeout_err  out  1      one-cycle pulse on forced release
// BEHAVIOUR
//  Reset (async assert, sync release): valid=0, idx=0, grant_oh=0, timeout_err=0, state S_IDLE,
//   ptr=0, tcnt=0.
//  FSM (all outputs registered):
//   S_IDLE:  |req=1 -> S_GRANT; winner computed from req in that cycle; next cycle valid=1,
//            idx=winner, grant_oh=1<<winner. Latency req->valid = 1 clk. |req=0 -> stay.
//   S_GRANT: idx/grant_oh frozen; later req changes ignored except req[idx].
//    ack=1                 -> S_IDLE, valid=0 next clk, ptr<=idx+1 (mod N_REQ).
//    ack=0, req[idx]=0     -> S_IDLE, valid=0 next clk, ptr unchanged (withdrawn request).
//    ack=0, tcnt=TIMEOUT-1 -> S_IDLE, valid=0, timeout_err=1 for 1 clk, ptr<=idx+1.
//    Priority on simultaneous events: ack > withdraw > timeout.
//  Back-to-back: after release, one S_IDLE cycle; max grant rate is one grant per 2 clk.
//  tcnt: cleared on entry to S_GRANT, increments each S_GRANT cycle, $clog2(TIMEOUT+1) bits,
//   saturating. TIMEOUT=0 removes the timeout path.
//  Winner search: start at ptr, ascending, wrap N_REQ-1 -> 0; ptr=7 searches 7,0,1,...,6.
//  ack while valid=0 is ignored. idx is always < N_REQ; no X outputs in any state.
//  grant_oh=0 whenever valid=0.
//  Reset asserted mid-GRANT: outputs clear immediately; the grant is not remembered.
// CONFIGURATION
//  ROUND_ROBIN_EN defined: rotating priority as above; ptr updates on ack or timeout.
//  ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; ptr tied to 0 and never updated.
//   Timeout still releases the grant, but the same channel can re-win immediately.
// STRUCTURE
//  Package req_enc_pkg holds:
//   - IDX_W_DEF=3 and N_REQ_DEF=8
//   - typedef enum logic {S_IDLE, S_GRANT} req_enc_state_t
//   - function onehot(idx) returning 1<<idx
//  Sub-module rr_priority_pick: combinational. Inputs req and ptr; outputs any and win_idx.
//   Implemented as a double-width masked priority search. Instantiated once.
//  This top level owns the FSM, the ptr/tcnt registers and the output registers.
// TESTING
//  1 req=8'b0000_0100 in IDLE -> next clk valid=1, idx=2, grant_oh=8'b0000_0100; ack -> valid=0.
//  2 RR: req=8'hFF held with ack every grant -> idx sequence 0,1,...,7,0, one grant per 2 clk.
//    Without ROUND_ROBIN_EN -> idx=0 every time.
//  3 Wrap: ptr=7 (after granting 6), req=8'b1000_0001 -> idx=7; next grant idx=0.
//  4 Withdraw: grant idx=3, then req[3]=0 with ack=0 -> valid=0 next clk, timeout_err=0,
//    ptr unchanged (next grant of 8'hFF is idx=3).
//  5 Timeout (TIMEOUT=16): grant idx=5, no ack -> 16 clk after valid rises, valid=0,
//    timeout_err pulses once; with req=8'hFF the next idx is 6.
//    Ack and timeout in the same clk -> no timeout_err.
//  6 Async reset: assert reset_n=0 mid-GRANT between clock edges -> outputs 0 immediately;
//    after release, req=8'h80 -> idx=7.

Source files
------------

// File: rtl/req_priority_encoder_pkg.sv
// Shared types and constants for the request priority encoder.
// Holds the FSM state type, the default widths and the one-hot helper.
package req_enc_pkg;

    localparam int IDX_W_DEF = 3;
    localparam int N_REQ_DEF = 8;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } req_enc_state_t;

    function automatic logic [N_REQ_DEF-1:0] onehot(input logic [IDX_W_DEF-1:0] idx);
        return N_REQ_DEF'(1) << idx;
    endfunction

endpackage

// File: rtl/req_priority_encoder_if.sv
// Request/grant bundle between DMA request lines and the channel-select logic.
// master drives requests and ack; slave (the encoder) drives the grant side.
interface req_priority_encoder_if
    import req_enc_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
);
    localparam int N_REQ = 1 << IDX_W;

    logic [N_REQ-1:0] req;
    logic             ack;
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [N_REQ-1:0] grant_oh;
    logic             timeout_err;

    modport master (
        output req, ack,
        input  valid, idx, grant_oh, timeout_err
    );

    modport slave (
        input  req, ack,
        output valid, idx, grant_oh, timeout_err
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority search: lowest set request at or above ptr,
// wrapping past N_REQ-1 back to 0.
module rr_priority_pick #(
    parameter  int IDX_W = 3,
    localparam int N_REQ = 1 << IDX_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] win_idx
);

    logic [2*N_REQ-1:0] masked;

    // Upper copy is unmasked, so a miss above ptr falls through to the wrapped search.
    assign masked = {req, req} & ({(2*N_REQ){1'b1}} << ptr);
    assign any    = |req;

    always_comb begin
        win_idx = '0;
        for (int i = 2*N_REQ-1; i >= 0; i--) begin
            if (masked[i]) win_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/req_priority_encoder.sv
// Registered priority encoder with grant hold, ack/withdraw/timeout release.
// Define ROUND_ROBIN_EN for rotating priority; default build is fixed lowest-index priority.
module req_priority_encoder
    import req_enc_pkg::*;
#(
    parameter int IDX_W   = IDX_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    req_priority_encoder_if.slave  bus
);

    localparam int N_REQ  = 1 << IDX_W;
    localparam int TCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = (TIMEOUT > 0) ? TCNT_W'(TIMEOUT - 1) : '0;
    localparam logic [TCNT_W-1:0] TCNT_MAX  = '1;

    req_enc_state_t    state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              valid_q, valid_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [N_REQ-1:0]  grant_oh_q, grant_oh_d;
    logic              terr_q, terr_d;

    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic              timeout_hit;

    rr_priority_pick #(.IDX_W(IDX_W)) u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .any     (pick_any),
        .win_idx (pick_idx)
    );

    assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == TCNT_LAST);

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        tcnt_d     = tcnt_q;
        valid_d    = valid_q;
        idx_d      = idx_q;
        grant_oh_d = grant_oh_q;
        terr_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    state_d    = S_GRANT;
                    valid_d    = 1'b1;
                    idx_d      = pick_idx;
                    grant_oh_d = onehot(pick_idx);
                    tcnt_d     = '0;
                end
            end
            S_GRANT: begin
                if (tcnt_q != TCNT_MAX) tcnt_d = tcnt_q + TCNT_W'(1);
                // Release priority: ack, then withdrawn request, then timeout.
                if (bus.ack || !bus.req[idx_q] || timeout_hit) begin
                    state_d    = S_IDLE;
                    valid_d    = 1'b0;
                    grant_oh_d = '0;
                    terr_d     = !bus.ack && bus.req[idx_q];
`ifdef ROUND_ROBIN_EN
                    if (bus.ack || bus.req[idx_q]) ptr_d = idx_q + IDX_W'(1);
`else
                    ptr_d = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            tcnt_q     <= '0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            grant_oh_q <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            tcnt_q     <= tcnt_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            grant_oh_q <= grant_oh_d;
            terr_q     <= terr_d;
        end
    end

    assign bus.valid       = valid_q;
    assign bus.idx         = idx_q;
    assign bus.grant_oh    = grant_oh_q;
    assign bus.timeout_err = terr_q;

endmodule
